// File: rtl/clock_field_editor.sv
// Front-panel edit controller: mode/field selection, edge-detected buttons,
// change-button auto-repeat, idle timeout back to run mode.
module clock_field_editor #(
  parameter int unsigned N_MODES     = 3,
  parameter int unsigned N_FIELDS    = 2,
  parameter int unsigned TIMEOUT_CYC = 50000000,
  parameter int unsigned REPEAT_DLY  = 25000000,
  parameter int unsigned REPEAT_RATE = 5000000,
  localparam int unsigned MODE_W  = ($clog2(N_MODES) > 0) ? $clog2(N_MODES) : 1,
  localparam int unsigned FIELD_W = ($clog2(N_FIELDS) > 0) ? $clog2(N_FIELDS) : 1,
  localparam int unsigned N_INC   = (N_MODES - 1) * N_FIELDS
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mode_btn,
  input  logic               turn_btn,
  input  logic               change_btn,
  output logic [MODE_W-1:0]  mode_o,
  output logic [FIELD_W-1:0] field_o,
  output logic [N_INC-1:0]   inc_o,
  output logic [N_FIELDS-1:0] field_led,
  output logic               editing
);

  localparam int unsigned REP_MAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
  localparam int unsigned REP_W   = $clog2(REP_MAX + 1);
  localparam int unsigned IDLE_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [IDLE_W-1:0]  IDLE_MAX  = IDLE_W'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);
  localparam logic [MODE_W-1:0]  MODE_LAST = MODE_W'(N_MODES - 1);
  localparam logic [FIELD_W-1:0] FIELD_LAST = FIELD_W'(N_FIELDS - 1);
  localparam logic [REP_W-1:0]   REP_DLY_C  = REP_W'(REPEAT_DLY);
  localparam logic [REP_W-1:0]   REP_RATE_C = REP_W'(REPEAT_RATE);

  logic mode_prev, turn_prev, change_prev;
  logic [REP_W-1:0]  rep_cnt, rep_cnt_nxt;
  logic              repeating, repeating_nxt;
  logic [IDLE_W-1:0] idle_cnt, idle_cnt_nxt;
  logic [MODE_W-1:0] mode_nxt;
  logic [FIELD_W-1:0] field_nxt;
  logic [N_INC-1:0]  inc_nxt;
  logic [N_FIELDS-1:0] led_nxt;
  logic              editing_nxt;
  logic              press_m, press_t, press_c, fire;
  logic [REP_W-1:0]  rep_thr;
  int unsigned       inc_idx;

  // Next-state decode: press priority, auto-repeat, idle timeout
  always_comb begin
    press_m       = mode_btn & ~mode_prev;
    press_t       = turn_btn & ~turn_prev;
    press_c       = change_btn & ~change_prev;
    mode_nxt      = mode_o;
    field_nxt     = field_o;
    rep_cnt_nxt   = rep_cnt;
    repeating_nxt = repeating;
    idle_cnt_nxt  = idle_cnt;
    fire          = 1'b0;
    rep_thr       = repeating ? REP_RATE_C : REP_DLY_C;
    inc_idx       = (32'(mode_o) - 32'd1) * N_FIELDS + 32'(field_o);

    if (press_m) begin
      mode_nxt      = (mode_o == MODE_LAST) ? '0 : mode_o + MODE_W'(1);
      field_nxt     = '0;
      rep_cnt_nxt   = '0;
      repeating_nxt = 1'b0;
      idle_cnt_nxt  = '0;
    end else if (editing) begin
      if (press_c) begin
        fire          = 1'b1;
        rep_cnt_nxt   = (REPEAT_DLY != 0) ? REP_W'(1) : '0;
        repeating_nxt = 1'b0;
      end else if (rep_cnt != '0) begin
        if (!change_btn) begin
          rep_cnt_nxt   = '0;
          repeating_nxt = 1'b0;
        end else if (rep_cnt == rep_thr) begin
          fire          = 1'b1;
          rep_cnt_nxt   = REP_W'(1);
          repeating_nxt = 1'b1;
        end else begin
          rep_cnt_nxt = rep_cnt + REP_W'(1);
        end
      end
      // Turn advances after the pulse has already been routed to the old field
      if (press_t) begin
        field_nxt     = (field_o == FIELD_LAST) ? '0 : field_o + FIELD_W'(1);
        rep_cnt_nxt   = '0;
        repeating_nxt = 1'b0;
      end
      if (press_t || press_c || fire) begin
        idle_cnt_nxt = '0;
      end else if (TIMEOUT_CYC == 0) begin
        idle_cnt_nxt = '0;
      end else if (idle_cnt == IDLE_MAX) begin
        mode_nxt      = '0;
        field_nxt     = '0;
        idle_cnt_nxt  = '0;
        rep_cnt_nxt   = '0;
        repeating_nxt = 1'b0;
      end else begin
        idle_cnt_nxt = idle_cnt + IDLE_W'(1);
      end
    end else begin
      rep_cnt_nxt   = '0;
      repeating_nxt = 1'b0;
      idle_cnt_nxt  = '0;
    end

    for (int unsigned i = 0; i < N_INC; i++) begin
      inc_nxt[i] = fire && (i == inc_idx);
    end
    editing_nxt = (mode_nxt != '0);
    led_nxt     = editing_nxt ? (N_FIELDS'(1) << field_nxt) : '0;
  end

  // State and registered outputs; button history presets to 1 on reset
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_prev   <= 1'b1;
      turn_prev   <= 1'b1;
      change_prev <= 1'b1;
      mode_o      <= '0;
      field_o     <= '0;
      inc_o       <= '0;
      field_led   <= '0;
      editing     <= 1'b0;
      rep_cnt     <= '0;
      repeating   <= 1'b0;
      idle_cnt    <= '0;
    end else begin
      mode_prev   <= mode_btn;
      turn_prev   <= turn_btn;
      change_prev <= change_btn;
      mode_o      <= mode_nxt;
      field_o     <= field_nxt;
      inc_o       <= inc_nxt;
      field_led   <= led_nxt;
      editing     <= editing_nxt;
      rep_cnt     <= rep_cnt_nxt;
      repeating   <= repeating_nxt;
      idle_cnt    <= idle_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_clock_field_editor.sv
// Directed bench for clock_field_editor with an inc_o pulse scoreboard.
module tb_clock_field_editor;

  logic clk, rst, mode_btn, turn_btn, change_btn;
  logic [1:0] mode_o;
  logic [0:0] field_o;
  logic [3:0] inc_o;
  logic [1:0] field_led;
  logic       editing;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct { int cyc; logic [3:0] val; } ev_t;
  ev_t exp_q[$];

  clock_field_editor #(
    .N_MODES(3), .N_FIELDS(2), .TIMEOUT_CYC(20), .REPEAT_DLY(8), .REPEAT_RATE(4)
  ) dut (
    .clk(clk), .rst(rst), .mode_btn(mode_btn), .turn_btn(turn_btn),
    .change_btn(change_btn), .mode_o(mode_o), .field_o(field_o), .inc_o(inc_o),
    .field_led(field_led), .editing(editing)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter used to timestamp expected pulses
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every nonzero inc_o must match the oldest expected pulse
  always @(posedge clk) begin
    #1;
    if (inc_o != 4'b0000) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_inc: got %b at edge %0d, expected no pulse", inc_o, cyc);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        if (e.val !== inc_o || e.cyc != cyc) begin
          errors++;
          $display("FAIL inc_pulse: got %b at edge %0d, expected %b at edge %0d",
                   inc_o, cyc, e.val, e.cyc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_state(input string name, input int m, input int f, input int led,
                             input int ed);
    check({name, "_mode"}, int'(mode_o), m);
    check({name, "_field"}, int'(field_o), f);
    check({name, "_led"}, int'(field_led), led);
    check({name, "_editing"}, int'(editing), ed);
  endtask

  task automatic press_mode(input string name, input int m, input int led, input int ed);
    mode_btn = 1'b1;
    tick();
    check_state(name, m, 0, led, ed);
    mode_btn = 1'b0;
    tick();
  endtask

  task automatic expect_inc(input int at, input logic [3:0] v);
    ev_t e;
    e.cyc = at;
    e.val = v;
    exp_q.push_back(e);
  endtask

  initial begin
    rst = 1'b1; mode_btn = 1'b1; turn_btn = 1'b0; change_btn = 1'b1;
    tick(); tick();
    check_state("reset", 0, 0, 0, 0);
    check("reset_inc", int'(inc_o), 0);

    // Buttons held through reset must not count as presses
    rst = 1'b0;
    repeat (3) tick();
    check_state("held_thru_reset", 0, 0, 0, 0);
    mode_btn = 1'b0; change_btn = 1'b0;
    tick();

    press_mode("mode1", 1, 1, 1);
    press_mode("mode2", 2, 1, 1);
    press_mode("mode0", 0, 0, 0);

    // Routing in mode 2
    press_mode("to1", 1, 1, 1);
    press_mode("to2", 2, 1, 1);
    expect_inc(cyc + 1, 4'b0100);
    change_btn = 1'b1; tick(); change_btn = 1'b0; tick();
    turn_btn = 1'b1; tick();
    check_state("turn_m2", 2, 1, 2, 1);
    turn_btn = 1'b0; tick();
    expect_inc(cyc + 1, 4'b1000);
    change_btn = 1'b1; tick(); change_btn = 1'b0; tick();
    press_mode("back0", 0, 0, 0);
    turn_btn = 1'b1; change_btn = 1'b1; tick();
    check_state("run_ignores", 0, 0, 0, 0);
    turn_btn = 1'b0; change_btn = 1'b0; tick();

    // Auto-repeat in mode 1: pulses at press edge +0, +8, +12, +16
    press_mode("rep_m1", 1, 1, 1);
    expect_inc(cyc + 1, 4'b0001);
    expect_inc(cyc + 9, 4'b0001);
    expect_inc(cyc + 13, 4'b0001);
    expect_inc(cyc + 17, 4'b0001);
    change_btn = 1'b1;
    repeat (20) tick();
    change_btn = 1'b0;
    repeat (3) tick();

    // Timeout: mode 2 returns to run exactly 20 edges after the last press
    mode_btn = 1'b1; tick(); mode_btn = 1'b0;
    repeat (19) tick();
    check("timeout_pre", int'(mode_o), 2);
    tick();
    check_state("timeout", 0, 0, 0, 0);

    // A turn press at edge 19 restarts the idle count
    press_mode("to_t1", 1, 1, 1);
    mode_btn = 1'b1; tick(); mode_btn = 1'b0;
    check("to_t2_mode", int'(mode_o), 2);
    repeat (18) tick();
    turn_btn = 1'b1; tick(); turn_btn = 1'b0;
    check_state("turn_at19", 2, 1, 2, 1);
    repeat (19) tick();
    check("restart_pre", int'(mode_o), 2);
    tick();
    check_state("restart_timeout", 0, 0, 0, 0);

    // Mode press wins over simultaneous turn and change
    press_mode("sim_m1", 1, 1, 1);
    mode_btn = 1'b1; turn_btn = 1'b1; change_btn = 1'b1; tick();
    check_state("mode_wins", 2, 0, 1, 1);
    mode_btn = 1'b0; turn_btn = 1'b0; change_btn = 1'b0; tick();

    // Turn and change together: pulse to old field, then field advances
    press_mode("sim_m0", 0, 0, 0);
    press_mode("sim_m1b", 1, 1, 1);
    expect_inc(cyc + 1, 4'b0001);
    turn_btn = 1'b1; change_btn = 1'b1; tick();
    check_state("turn_change", 1, 1, 2, 1);
    turn_btn = 1'b0; change_btn = 1'b0;
    repeat (4) tick();

    check("pending_pulses", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clock_field_editor.md
Name: clock_field_editor

Overview:
Parametrised front-panel edit controller for the digital clock, generalising the earlier time/alarm adjust selector. It tracks the panel mode (run plus N_MODES-1 edit targets such as time and alarm) and the selected field within the target (minute, hour, ...). It turns debounced button levels into one-cycle increment pulses routed to the matching counter, and drives field indicator LEDs. Unlike the earlier selector, it is fully synchronous, edge-detects its buttons, auto-repeats a held change button, and drops back to run mode after an idle timeout.

Parameters:
N_MODES, 3, total modes; mode 0 = run, modes 1..N_MODES-1 = edit targets (1 = alarm, 2 = time by default); minimum 2
N_FIELDS, 2, editable fields per target; field 0 = minute, field 1 = hour, higher fields are target-defined; minimum 1
TIMEOUT_CYC, 50000000, idle clk cycles in an edit mode before forced return to mode 0; 0 disables timeout
REPEAT_DLY, 25000000, clk cycles change_btn must be held before auto-repeat starts; 0 disables auto-repeat
REPEAT_RATE, 5000000, clk cycles between auto-repeat pulses; minimum 1
(derived) MODE_W = max(1, clog2(N_MODES)); FIELD_W = max(1, clog2(N_FIELDS)); N_INC = (N_MODES-1)*N_FIELDS

Ports:
clk  input  1  system clock; all state changes on rising edge
rst  input  1  synchronous, active-high reset
mode_btn  input  1  debounced level; each press advances the mode
turn_btn  input  1  debounced level; each press advances the field in edit modes
change_btn  input  1  debounced level; each press (and auto-repeat) increments the selected field
mode_o  output  MODE_W  current mode
field_o  output  FIELD_W  current field index
inc_o  output  N_INC  one-hot, one-cycle increment pulses; bit (mode-1)*N_FIELDS+field
field_led  output  N_FIELDS  one-hot selected-field indicator; all 0 in mode 0
editing  output  1  high when mode_o != 0

Behaviour:
- Reset (rst=1 at a clk edge): mode_o=0, field_o=0, inc_o=0, field_led=0, editing=0; timeout and repeat counters cleared. Button history registers are set to 1, so a button held through reset does not register a press until it is released and pressed again.
- Press detect: press_x = x_btn & ~x_prev, evaluated at each clk edge; x_prev <= x_btn every cycle. All register updates caused by a press take effect on that same edge. inc_o is registered, so the pulse is high for exactly the one cycle after detection.
- Mode press: mode <= (mode==N_MODES-1) ? 0 : mode+1. The field resets to 0 on every mode change, including timeout.
- Turn press: only in edit modes; field <= (field==N_FIELDS-1) ? 0 : field+1. Ignored in mode 0.
- Change press: only in edit modes; pulses inc_o bit (mode-1)*N_FIELDS+field for 1 cycle. In mode 0, no pulse is produced and the repeat counter stays at 0.
- Auto-repeat: while in an edit mode and change_btn stays high after a press, the repeat counter counts cycles. The first repeat pulse occurs REPEAT_DLY cycles after the press pulse; later pulses follow every REPEAT_RATE cycles. Releasing change_btn, any mode or turn press, or leaving edit mode clears the counter immediately.
- Timeout: in edit modes, the idle counter increments each cycle and is cleared by any press or auto-repeat pulse. When it reaches TIMEOUT_CYC-1, on the next edge mode<=0 and field<=0. No inc pulse is produced on that edge.
- Simultaneous events in one cycle:
  - mode press wins; turn and change presses in the same cycle are discarded.
  - turn and change together: the inc pulse goes to the OLD field, and the field then advances.
  - a press in the same cycle as timeout expiry cancels the timeout and the press is applied.
- field_led = (editing) ? (1 << field) : 0. editing = (mode != 0). Both are registered and consistent with mode_o/field_o in the same cycle.
- inc_o never has more than one bit set.
- Counter widths are sized to hold their parameter values without wrap.

Test Plan:
- Params N_MODES=3, N_FIELDS=2, TIMEOUT_CYC=20, REPEAT_DLY=8, REPEAT_RATE=4. Assert rst 2 cycles -> all outputs 0. Hold change_btn high across rst release -> no inc_o pulse until change_btn is released and pressed again.
- Press mode_btn 3 times -> mode_o 1,2,0. field_led 01,01,00. editing 1,1,0.
- mode_o=2, field 0: press change_btn -> inc_o=0100 for 1 cycle. Press turn -> field_led=10. Press change -> inc_o=1000. Mode 0: press turn and change -> no output change.
- mode_o=1: hold change_btn for 20 cycles -> inc_o=0001 pulses at cycles 1, 9, 13, 17 relative to the press edge. Release -> pulses stop.
- mode_o=2, no buttons pressed -> mode_o returns to 0 exactly 20 cycles after the last press. A turn press at cycle 19 -> no timeout; the counter restarts.
- mode, turn and change pressed in the same cycle at mode_o=1 -> mode_o=2, field 0, no inc pulse. Turn and change together at mode_o=1, field 0 -> inc_o=0001, then field_led=10.
